operands_reader: RTL and testbench

Read-side sequencer for the matrix operand register file. On a start pulse it walks the row addresses of operand A and operand B, captures each BUS_WIDTH-wide row pair, and streams it out one DATA_WIDTH element pair at a time over a valid/ready handshake. It sits between the operand register file and the multiply/accumulate datapath, and stalls whenever the APB side is writing the register file.

---
 rtl/operands_pkg.sv | 28 ++
 rtl/operands_reader_if.sv | 28 ++
 rtl/operands_row_unpacker.sv | 43 ++++
 rtl/operands_reader.sv | 140 ++++++++++++++
 tb/tb_operands_reader.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/operands_pkg.sv
// Shared definitions for the matrix operand register file and its read-side sequencer.
// Widths are derived from the element and row widths so every user agrees on counter sizes.
package operands_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_BUS_WIDTH  = 64;

  function automatic int max_dim(input int bus_w, input int data_w);
    return bus_w / data_w;
  endfunction

  function automatic int cnt_width(input int bus_w, input int data_w);
    int dim;
    dim = bus_w / data_w;
    return (dim > 1) ? $clog2(dim) : 1;
  endfunction

  localparam int DEFAULT_MAX_DIM = max_dim(DEFAULT_BUS_WIDTH, DEFAULT_DATA_WIDTH);
  localparam int DEFAULT_CNT_W   = cnt_width(DEFAULT_BUS_WIDTH, DEFAULT_DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/operands_reader_if.sv
// Element-pair stream from the operand reader to the multiply/accumulate datapath.
interface operands_reader_if
  import operands_pkg::*;
#(
  parameter int  DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int  BUS_WIDTH  = DEFAULT_BUS_WIDTH,
  localparam int CNT_W      = cnt_width(BUS_WIDTH, DATA_WIDTH)
);

  logic [DATA_WIDTH-1:0] a_elem;
  logic [DATA_WIDTH-1:0] b_elem;
  logic [CNT_W-1:0]      row;
  logic [CNT_W-1:0]      col;
  logic                  valid;
  logic                  ready;
  logic                  last;

  modport master (
    output a_elem, b_elem, row, col, valid, last,
    input  ready
  );

  modport slave (
    input  a_elem, b_elem, row, col, valid, last,
    output ready
  );

endinterface

// File: rtl/operands_row_unpacker.sv
// Holds one captured operand row and selects a single element of it by column index.
module operands_row_unpacker
  import operands_pkg::*;
#(
  parameter int  DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int  BUS_WIDTH  = DEFAULT_BUS_WIDTH,
  localparam int MAX_DIM    = max_dim(BUS_WIDTH, DATA_WIDTH),
  localparam int CNT_W      = cnt_width(BUS_WIDTH, DATA_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  capture_i,
  input  logic [BUS_WIDTH-1:0]  row_i,
  input  logic [CNT_W-1:0]      sel_i,
  output logic [DATA_WIDTH-1:0] elem_o
);

  logic [BUS_WIDTH-1:0]  row_reg;
  logic [DATA_WIDTH-1:0] elems [MAX_DIM];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_reg <= '0;
    end else if (capture_i) begin
      row_reg <= row_i;
    end
  end

  for (genvar gi = 0; gi < MAX_DIM; gi++) begin : g_slice
    assign elems[gi] = row_reg[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Compare-based mux so a select beyond MAX_DIM-1 yields zero instead of an out-of-range read.
  always_comb begin
    elem_o = '0;
    for (int i = 0; i < MAX_DIM; i++) begin
      if (sel_i == CNT_W'(i)) begin
        elem_o = elems[i];
      end
    end
  end

endmodule

// File: rtl/operands_reader.sv
// Read-side sequencer: fetches A/B operand rows and streams them as element pairs,
// holding in FETCH while the register file is being written.
module operands_reader
  import operands_pkg::*;
#(
  parameter int  DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int  BUS_WIDTH  = DEFAULT_BUS_WIDTH,
  localparam int MAX_DIM    = max_dim(BUS_WIDTH, DATA_WIDTH),
  localparam int CNT_W      = cnt_width(BUS_WIDTH, DATA_WIDTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [CNT_W-1:0]     rows_i,
  input  logic [CNT_W-1:0]     cols_i,
  input  logic                 wr_busy_i,
  output logic [CNT_W-1:0]     address_o,
  output logic [CNT_W-1:0]     address_op_o,
  input  logic [BUS_WIDTH-1:0] data_i,
  input  logic [BUS_WIDTH-1:0] data_op_i,
  output logic                 busy_o,
  output logic                 done_o,
  operands_reader_if.master    stream_if
);

  state_e           state_reg, state_next;
  logic [CNT_W-1:0] rows_reg, rows_next;
  logic [CNT_W-1:0] cols_reg, cols_next;
  logic [CNT_W-1:0] row_cnt_reg, row_cnt_next;
  logic [CNT_W-1:0] col_cnt_reg, col_cnt_next;
  logic             capture;
  logic             row_last;
  logic             col_last;

  function automatic logic [CNT_W-1:0] clamp_dim(input logic [CNT_W-1:0] v);
    if (int'(v) > MAX_DIM - 1) begin
      return CNT_W'(MAX_DIM - 1);
    end
    return v;
  endfunction

  assign row_last = (row_cnt_reg == rows_reg);
  assign col_last = (col_cnt_reg == cols_reg);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg   <= IDLE;
      rows_reg    <= '0;
      cols_reg    <= '0;
      row_cnt_reg <= '0;
      col_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      rows_reg    <= rows_next;
      cols_reg    <= cols_next;
      row_cnt_reg <= row_cnt_next;
      col_cnt_reg <= col_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    rows_next    = rows_reg;
    cols_next    = cols_reg;
    row_cnt_next = row_cnt_reg;
    col_cnt_next = col_cnt_reg;
    capture      = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (start_i) begin
          rows_next    = clamp_dim(rows_i);
          cols_next    = clamp_dim(cols_i);
          row_cnt_next = '0;
          state_next   = FETCH;
        end
      end
      FETCH: begin
        // Read data is meaningless while the write port owns the file.
        if (!wr_busy_i) begin
          capture      = 1'b1;
          col_cnt_next = '0;
          state_next   = STREAM;
        end
      end
      STREAM: begin
        if (stream_if.ready) begin
          if (!col_last) begin
            col_cnt_next = col_cnt_reg + CNT_W'(1);
          end else if (!row_last) begin
            row_cnt_next = row_cnt_reg + CNT_W'(1);
            state_next   = FETCH;
          end else begin
            state_next   = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  operands_row_unpacker #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUS_WIDTH  (BUS_WIDTH)
  ) u_unpack_a (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .capture_i (capture),
    .row_i     (data_i),
    .sel_i     (col_cnt_reg),
    .elem_o    (stream_if.a_elem)
  );

  operands_row_unpacker #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUS_WIDTH  (BUS_WIDTH)
  ) u_unpack_b (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .capture_i (capture),
    .row_i     (data_op_i),
    .sel_i     (col_cnt_reg),
    .elem_o    (stream_if.b_elem)
  );

  assign address_o        = row_cnt_reg;
  assign address_op_o     = row_cnt_reg;
  assign stream_if.row    = row_cnt_reg;
  assign stream_if.col    = col_cnt_reg;
  assign stream_if.valid  = (state_reg == STREAM);
  assign stream_if.last   = (state_reg == STREAM) && row_last && col_last;
  assign busy_o           = (state_reg != IDLE);
  assign done_o           = (state_reg == DONE);

endmodule

// File: tb/tb_operands_reader.sv
// Directed bench for operands_reader: full, backpressured, stalled, partial and reset-interrupted transfers.
module tb_operands_reader;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [1:0]  rows_i;
  logic [1:0]  cols_i;
  logic        wr_busy_i;
  logic [1:0]  address_o;
  logic [1:0]  address_op_o;
  logic [63:0] data_i;
  logic [63:0] data_op_i;
  logic        busy_o;
  logic        done_o;
  logic [63:0] mem_a [4];
  logic [63:0] mem_b [4];

  int checks = 0;
  int errors = 0;

  operands_reader_if #(.DATA_WIDTH(16), .BUS_WIDTH(64)) s_if ();

  operands_reader #(
    .DATA_WIDTH (16),
    .BUS_WIDTH  (64)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .rows_i       (rows_i),
    .cols_i       (cols_i),
    .wr_busy_i    (wr_busy_i),
    .address_o    (address_o),
    .address_op_o (address_op_o),
    .data_i       (data_i),
    .data_op_i    (data_op_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .stream_if    (s_if.master)
  );

  always #5 clk_i = ~clk_i;

  // Register file model: garbage on the read port while a write is in progress.
  assign data_i    = wr_busy_i ? 64'hDEAD_BEEF_DEAD_BEEF : mem_a[address_o];
  assign data_op_i = wr_busy_i ? 64'hBEEF_DEAD_BEEF_DEAD : mem_b[address_op_o];

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_value({tag, "_valid"}, 64'(s_if.valid), 64'd0);
    check_value({tag, "_last"},  64'(s_if.last),  64'd0);
    check_value({tag, "_busy"},  64'(busy_o),     64'd0);
    check_value({tag, "_done"},  64'(done_o),     64'd0);
    check_value({tag, "_a"},     64'(s_if.a_elem), 64'd0);
    check_value({tag, "_b"},     64'(s_if.b_elem), 64'd0);
    check_value({tag, "_row"},   64'(s_if.row),   64'd0);
    check_value({tag, "_col"},   64'(s_if.col),   64'd0);
    check_value({tag, "_addr"},  64'(address_o),  64'd0);
    check_value({tag, "_addrb"}, 64'(address_op_o), 64'd0);
  endtask

  // Element (r,c) of A holds 4*r+c+1; B holds the same plus 0x10.
  task automatic run_transfer(input int rows, input int cols, input int stall,
                              input bit bp, input bit poke);
    int   k = 0;
    int   total;
    int   first_valid = -1;
    int   done_cyc = -1;
    int   ph = 0;
    int   exp_row;
    int   exp_col;
    bit   rdy;
    bit   prev_valid = 1'b0;
    bit   prev_rdy = 1'b1;
    logic [15:0] prev_a = '0;
    logic [15:0] prev_b = '0;
    total = (rows + 1) * (cols + 1);
    @(negedge clk_i);
    start_i = 1'b1; rows_i = 2'(rows); cols_i = 2'(cols); s_if.ready = 1'b0; wr_busy_i = 1'b0;
    @(negedge clk_i);
    for (int c = 1; c <= 200; c++) begin
      wr_busy_i = (c <= stall);
      if (poke && c == 4) begin
        start_i = 1'b1; rows_i = 2'd0; cols_i = 2'd0;
      end else begin
        start_i = 1'b0;
      end
      if (c == 1) check_value("busy_fetch", 64'(busy_o), 64'd1);
      rdy = bp ? ((ph % 4 == 0) || (ph % 4 == 3)) : 1'b1;
      s_if.ready = rdy;
      exp_row = (k < total) ? k / (cols + 1) : rows;
      exp_col = k % (cols + 1);
      if (k < total) check_value("address", 64'(address_o), 64'(exp_row));
      if (c < 2 + stall) check_value("no_valid_early", 64'(s_if.valid), 64'd0);
      if (prev_valid && !prev_rdy) begin
        check_value("hold_valid", 64'(s_if.valid), 64'd1);
        check_value("hold_a", 64'(s_if.a_elem), 64'(prev_a));
        check_value("hold_b", 64'(s_if.b_elem), 64'(prev_b));
      end
      if (s_if.valid) begin
        if (first_valid < 0) first_valid = c;
        check_value("a_elem", 64'(s_if.a_elem), 64'(4 * exp_row + exp_col + 1));
        check_value("b_elem", 64'(s_if.b_elem), 64'(4 * exp_row + exp_col + 1 + 16));
        check_value("row", 64'(s_if.row), 64'(exp_row));
        check_value("col", 64'(s_if.col), 64'(exp_col));
        check_value("last", 64'(s_if.last), 64'(k == total - 1));
        if (rdy) begin
          $display("pair %0d: row=%0d col=%0d a=%h b=%h last=%b",
                   k, s_if.row, s_if.col, s_if.a_elem, s_if.b_elem, s_if.last);
          k++;
        end
        ph++;
      end else begin
        check_value("last_unqualified", 64'(s_if.last), 64'd0);
      end
      prev_valid = s_if.valid; prev_rdy = rdy; prev_a = s_if.a_elem; prev_b = s_if.b_elem;
      if (done_o) begin
        done_cyc = c;
        break;
      end
      @(negedge clk_i);
    end
    wr_busy_i = 1'b0;
    if (done_cyc < 0) begin
      check_value("done_timeout", 64'd0, 64'd1);
    end else begin
      check_value("pair_count", 64'(k), 64'(total));
      check_value("first_valid_cycle", 64'(first_valid), 64'(2 + stall));
      // FETCH entry is cycle 1; DONE follows (rows+1)*(cols+2) cycles later plus stalls.
      if (!bp) check_value("done_cycle", 64'(done_cyc - 1), 64'(stall + (rows + 1) * (cols + 2)));
      start_i = 1'b1; rows_i = 2'd3; cols_i = 2'd3;
      @(negedge clk_i);
      start_i = 1'b0;
      check_value("idle_after_done", 64'(busy_o), 64'd0);
      check_value("done_pulse_width", 64'(done_o), 64'd0);
      @(negedge clk_i);
      check_value("start_in_done_ignored", 64'(busy_o), 64'd0);
    end
  endtask

  task automatic reset_mid_stream();
    int hs = 0;
    @(negedge clk_i);
    start_i = 1'b1; rows_i = 2'd1; cols_i = 2'd3; s_if.ready = 1'b1; wr_busy_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (s_if.valid) hs++;
      if (hs == 3) break;
      @(negedge clk_i);
    end
    check_value("reset_reached_3_handshakes", 64'(hs), 64'd3);
    @(posedge clk_i);
    #2;
    check_value("pre_reset_valid", 64'(s_if.valid), 64'd1);
    rst_ni = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      check_value("no_done_after_reset", 64'(done_o), 64'd0);
      check_value("idle_after_reset", 64'(busy_o), 64'd0);
    end
  endtask

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; wr_busy_i = 1'b0; s_if.ready = 1'b0;
    rows_i = 2'd0; cols_i = 2'd0;
    mem_a[0] = 64'h0004_0003_0002_0001; mem_b[0] = 64'h0014_0013_0012_0011;
    mem_a[1] = 64'h0008_0007_0006_0005; mem_b[1] = 64'h0018_0017_0016_0015;
    mem_a[2] = 64'h000C_000B_000A_0009; mem_b[2] = 64'h001C_001B_001A_0019;
    mem_a[3] = 64'h0010_000F_000E_000D; mem_b[3] = 64'h0020_001F_001E_001D;
    #12;
    check_all_zero("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;

    run_transfer(1, 3, 0, 1'b0, 1'b1);  // full 2x4, start poked mid-stream
    run_transfer(1, 3, 0, 1'b1, 1'b0);  // backpressure 1,0,0,1
    run_transfer(1, 3, 3, 1'b0, 1'b0);  // write collision in FETCH
    run_transfer(0, 1, 0, 1'b0, 1'b0);  // partial dims
    run_transfer(3, 3, 0, 1'b0, 1'b0);  // full 4x4
    reset_mid_stream();
    run_transfer(1, 3, 0, 1'b0, 1'b0);  // clean run after reset

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
